// File: rtl/fp32_tap_reducer.sv
// fp32_tap_reducer: buffers fp32 tap products (each tagged add/sub) and reduces
// every group of N_TERMS products to one fp32 sum by sequencing serial
// transactions into a single external fp32 adder/subtractor.
module fp32_tap_reducer #(
  parameter int N_TERMS    = 8,   // products per group, >= 1
  parameter int FIFO_DEPTH = 16,  // power of two, >= 2
  parameter int TIMEOUT    = 64   // max cycles waiting on the adder, >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] add_dina,
  output logic [31:0] add_dinb,
  output logic        add_op,
  output logic        add_valid_in,
  input  logic [31:0] add_result,
  input  logic        add_valid_out,
  output logic        busy,
  output logic        err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = $clog2(N_TERMS + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [KW-1:0] K_LAST = KW'(N_TERMS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t state, state_n;

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [31:0]   head_data;
  logic          head_sub;

  logic [31:0]   acc;
  logic [KW-1:0] k;
  logic [TW-1:0] timer;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = in_valid & ~full;
  assign head_data = mem[rd_ptr][31:0];
  assign head_sub  = mem[rd_ptr][32];

  assign in_ready  = ~full;
  assign out_valid = (state == S_DONE);
  assign out_data  = (state == S_DONE) ? acc : '0;
  assign busy      = (state != S_IDLE);

  // FIFO storage: write the {sub, data} entry on every accepted push.
  // NOTE: the storage array has no reset; emptiness is tracked by count alone,
  // so stale entries are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_sub, in_data};
  end

  // FIFO pointers and occupancy; a reset discards every buffered term.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and FIFO pop decode.
  // NOTE: every output of this block is given a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = (N_TERMS == 1) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (add_valid_out)        state_n = (k == K_LAST) ? S_DONE : S_ISSUE;
        else if (timer == T_LAST) state_n = S_IDLE;
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: accumulator, term counter, adder interface and timeout flag.
  // The adder operands hold between issues; valid_in is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      k            <= '0;
      timer        <= '0;
      add_dina     <= '0;
      add_dinb     <= '0;
      add_op       <= 1'b0;
      add_valid_in <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      add_valid_in <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            // A subtracted first term only needs its sign flipped.
            acc <= head_sub ? {~head_data[31], head_data[30:0]} : head_data;
            k   <= KW'(1);
          end
        end
        S_ISSUE: begin
          if (!empty) begin
            add_dina     <= acc;
            add_dinb     <= head_data;
            add_op       <= head_sub;
            add_valid_in <= 1'b1;
            timer        <= '0;
          end
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (add_valid_out) begin
            acc <= add_result;
            k   <= k + 1'b1;
          end else if (timer == T_LAST) begin
            // Abort the group; terms still buffered start the next one.
            err_timeout <= 1'b1;
            acc         <= '0;
            k           <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
